game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller for the dinosaur game. It conditions the active-low start, pause and jump buttons and runs a four-state game FSM. It also generates the one-cycle game tick that paces the player and obstacle update blocks, and drives their active-low pause and per-round reset. It keeps the running score and speed level consumed by the display and obstacle spawner.

## Interface
- TICK_DIV, 50000, system clocks per game tick (≥1)
- LEVEL_SCORE, 100, score points per speed-level increment (≥1)
- DEBOUNCE_CYCLES, 20000, stable-low cycles required for a press (used only with BTN_DEBOUNCE_EN)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start_btn  in  1  raw start button, active-low
- pause_btn  in  1  raw pause button, active-low
- jump_btn  in  1  raw jump button, active-low
- collision  in  1  player/obstacle overlap, synchronous to clk, active-high
- tick  out  1  one-cycle game-tick pulse
- jump  out  1  jump request to player block, active-low, low for exactly one cycle
- pause  out  1  low = updates enabled; high in every state but RUN
- game_reset  out  1  active-low round reset to update blocks, low for one cycle
- state  out  2  IDLE=0, RUN=1, PAUSED=2, OVER=3
- score  out  16  ticks survived this round, saturating
- level  out  3  speed level, saturating at 7

## Operation
- Buttons: per-button 2-flop synchronizer, then falling-edge detect; a press is a one-cycle event. Held buttons produce one event only.
- IDLE: divider held at 0, no tick. A start press clears score, level and divider, pulses game_reset low, and enters RUN.
- RUN:
  - Divider counts 0..TICK_DIV−1 and wraps.
  - tick is high in the cycle the divider equals TICK_DIV−1.
  - On tick, score increments, saturating at 16'hFFFF.
  - level increments when the new score is a nonzero multiple of LEVEL_SCORE, saturating at 7.
- RUN events, in priority order:
  1. collision high → OVER.
  2. Pause press → PAUSED.
  3. Jump press → jump low one cycle.
  - Start presses in RUN are ignored.
- PAUSED: divider, score and level frozen; no tick, no jump. A pause press returns to RUN, and the divider resumes from its frozen value.
- OVER: everything frozen, score held for display. A start press acts exactly as in IDLE (clear, game_reset pulse, RUN).
- Presses not consumed in the current state are discarded, never queued.
- Collision in the same cycle as a would-be tick: no tick, no score increment.

## Timing
- Reset values: state=IDLE, tick=0, jump=1, pause=1, game_reset=1, score=0, level=0, divider=0, synchronizers=1 (released).
- Press latency (no debounce): a button low before edge k is seen in sync stage 1 at k and stage 2 at k+1. The event is high in the cycle after k+1. Registered effects (state, jump, game_reset) are visible after edge k+2.
- pause output is registered from state and changes on the same edge as state.
- game_reset is low in the first cycle state reads RUN after IDLE/OVER. The divider is 0 in that cycle, so the first tick follows TICK_DIV−1 cycles later.
- TICK_DIV=1: tick is high every RUN cycle.
- Reset asserted mid-round forces all reset values immediately; any pending pulse is dropped.

## Configuration
- BTN_DEBOUNCE_EN defined:
  - Each synchronized button must be stable for DEBOUNCE_CYCLES consecutive cycles before its filtered level changes.
  - The edge is detected on the filtered level, adding DEBOUNCE_CYCLES cycles to press latency.
  - Glitches shorter than that produce no event.
- Undefined: synchronizer and edge detect only; DEBOUNCE_CYCLES is unused.

## Structure
- Shared package game_pkg:
  - state encoding constants (IDLE/RUN/PAUSED/OVER)
  - score and level widths
  - score and level saturation values
- Sub-module btn_conditioner:
  - synchronizer, optional debounce counter and falling-edge detector
  - instantiated three times
  - outputs one press-event bit

## Test plan
- Reset, then start press with TICK_DIV=4 → game_reset low for one cycle, state=1, pause=0, first tick 3 cycles after game_reset, then every 4 cycles.
- RUN for 5 ticks with LEVEL_SCORE=2 → score=5, level=2; a pause press freezes the divider; a second pause press resumes with the same tick phase.
- Jump held low for 50 cycles in RUN → exactly one jump-low cycle; jump press in PAUSED → jump stays high.
- collision and pause press in the same cycle, on a would-be tick → state=3, no tick, score unchanged; start press → score=0, state=1.
- Preload score 16'hFFFE, level 7, run 3 ticks → score 16'hFFFF, level 7.
- With BTN_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 5-cycle start glitch → stays IDLE; a 10-cycle press → RUN.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, widths and saturation limits for the game sequencer
//
// Contents:
//   game_state_e    : IDLE=0, RUN=1, PAUSED=2, OVER=3
//   SCORE_W/LEVEL_W : score and level widths
//   SCORE_MAX       : score saturation value
//   LEVEL_MAX       : level saturation value
//   level_sat_inc() : level increment that sticks at LEVEL_MAX
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } game_state_e;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned LEVEL_W = 3;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

  function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] lvl);
    if (lvl == LEVEL_MAX) begin
      return lvl;
    end
    return lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_btn_conditioner.sv
// rtl/game_sequencer_btn_conditioner.sv - button synchronizer, optional debounce and press detector
//
// Optional feature macro: BTN_DEBOUNCE_EN (adds a stability filter of DEBOUNCE_CYCLES cycles).
//
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_ni  : raw button, active-low, asynchronous to clk_i
//   press_o : one-cycle press event (falling edge of the conditioned level)
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level_w;

  // Released (high) is the reset level so nothing looks like a press after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // The counter runs only while the synchronized input disagrees with the
  // filtered level; any bounce back to the filtered level restarts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      filt_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign level_w = filt_q;
`else
  assign level_w = sync2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_w;
    end
  end

  // Combinational so the event is visible in the cycle the level first reads low.
  assign press_o = prev_q & ~level_w;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game-flow FSM, tick divider, score and speed level for the dinosaur game
//
// Optional feature macro: BTN_DEBOUNCE_EN (debounce filter in each button conditioner).
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   start_btn  : raw start button, active-low
//   pause_btn  : raw pause button, active-low
//   jump_btn   : raw jump button, active-low
//   collision  : player/obstacle overlap, active-high
//   tick       : one-cycle game-tick pulse
//   jump       : jump request, active-low one-cycle pulse
//   pause      : high in every state except RUN
//   game_reset : active-low one-cycle round reset
//   state      : IDLE=0, RUN=1, PAUSED=2, OVER=3
//   score      : ticks survived this round, saturating
//   level      : speed level, saturating at 7
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned LEVEL_SCORE     = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               jump_btn,
  input  logic               collision,
  output logic               tick,
  output logic               jump,
  output logic               pause,
  output logic               game_reset,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic start_press;
  logic pause_press;
  logic jump_press;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_ni (start_btn),
    .press_o(start_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_ni (pause_btn),
    .press_o(pause_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_btn (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_ni (jump_btn),
    .press_o(jump_press)
  );

  game_state_e        state_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_inc;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               jump_q;
  logic               pause_q;
  logic               game_reset_q;
  logic               tick_w;

  // A collision wins over the tick it coincides with: the round ends on the
  // previous score.
  assign tick_w  = (state_q == ST_RUN) && (div_q == DIV_LAST) && !collision;
  assign div_inc = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

  // Level only advances on a real score change, so a saturated score cannot
  // keep bumping the level.
  always_comb begin
    score_d = score_q;
    level_d = level_q;
    if (tick_w && (score_q != SCORE_MAX)) begin
      score_d = score_q + SCORE_W'(1);
      if ((32'(score_d) % LEVEL_SCORE) == 0) begin
        level_d = level_sat_inc(level_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      score_q      <= '0;
      level_q      <= '0;
      jump_q       <= 1'b1;
      pause_q      <= 1'b1;
      game_reset_q <= 1'b1;
    end else begin
      jump_q       <= 1'b1;
      game_reset_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_press) begin
            state_q      <= ST_RUN;
            pause_q      <= 1'b0;
            game_reset_q <= 1'b0;
            div_q        <= '0;
            score_q      <= '0;
            level_q      <= '0;
          end
        end
        ST_RUN: begin
          if (collision) begin
            state_q <= ST_OVER;
            pause_q <= 1'b1;
          end else begin
            // The cycle a pause is taken still counts as a RUN cycle, so the
            // divider phase carries across the pause unchanged.
            div_q   <= div_inc;
            score_q <= score_d;
            level_q <= level_d;
            if (pause_press) begin
              state_q <= ST_PAUSED;
              pause_q <= 1'b1;
            end else if (jump_press) begin
              jump_q <= 1'b0;
            end
          end
        end
        ST_PAUSED: begin
          if (pause_press) begin
            state_q <= ST_RUN;
            pause_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pause_q <= 1'b1;
        end
      endcase
    end
  end

  assign tick       = tick_w;
  assign jump       = jump_q;
  assign pause      = pause_q;
  assign game_reset = game_reset_q;
  assign state      = state_q;
  assign score      = score_q;
  assign level      = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int LS = 2;
`ifdef BTN_DEBOUNCE_EN
  localparam int DEB = 8;
`else
  localparam int DEB = 0;
`endif
  localparam int EV  = 2 + DEB;
  localparam int LAT = EV + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_btn = 1'b1;
  logic pause_btn = 1'b1;
  logic jump_btn = 1'b1;
  logic collision = 1'b0;
  logic tick, jump, pause, game_reset;
  logic [1:0] state;
  logic [15:0] score;
  logic [2:0] level;

  logic s_start = 1'b1;
  logic s_tick, s_jump, s_pause, s_game_reset;
  logic [1:0] s_state;
  logic [15:0] s_score;
  logic [2:0] s_level;

  game_sequencer #(.TICK_DIV(TD), .LEVEL_SCORE(LS), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .jump_btn(jump_btn), .collision(collision), .tick(tick), .jump(jump),
    .pause(pause), .game_reset(game_reset), .state(state), .score(score), .level(level)
  );

  game_sequencer #(.TICK_DIV(1), .LEVEL_SCORE(LS), .DEBOUNCE_CYCLES(8)) dut_sat (
    .clk(clk), .reset(reset), .start_btn(s_start), .pause_btn(1'b1),
    .jump_btn(1'b1), .collision(1'b0), .tick(s_tick), .jump(s_jump),
    .pause(s_pause), .game_reset(s_game_reset), .state(s_state), .score(s_score), .level(s_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mdl_div = 0;
  logic [15:0] mdl_score = '0;
  logic [2:0] mdl_level = '0;
  bit mdl_run = 1'b0;
  int jump_lows = 0;
  int gr_lows = 0;

  logic [15:0] exp_q[$];
  bit mon_en = 1'b0;
  bit pend_valid = 1'b0;
  logic [15:0] pend_val;

  // Scoreboard consumer: each observed tick pops the score it must produce.
  always @(negedge clk) begin
    if (pend_valid) begin
      checks++;
      if (score !== pend_val) begin
        errors++;
        $display("FAIL tick_score: score=%0d expected %0d", score, pend_val);
      end
      pend_valid = 1'b0;
    end
    if (mon_en && tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: tick=1 expected 0 (state=%0d)", state);
      end else begin
        pend_val = exp_q.pop_front();
        pend_valid = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances n cycles, predicting tick from the bench's own divider model and
  // pushing the score each predicted tick must yield.
  task automatic run_cycles(input int n);
    bit exp_tick;
    for (int i = 0; i < n; i++) begin
      exp_tick = mdl_run && (mdl_div == TD - 1) && !collision;
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_phase: tick=%0b expected %0b (model div %0d)", tick, exp_tick, mdl_div);
      end
      if (exp_tick) begin
        if (mdl_score != 16'hFFFF) begin
          mdl_score = mdl_score + 16'd1;
          if ((mdl_score % LS) == 0 && mdl_level != 3'd7) mdl_level = mdl_level + 3'd1;
        end
        exp_q.push_back(mdl_score);
      end
      if (mdl_run && !collision) mdl_div = (mdl_div + 1) % TD;
      if (jump === 1'b0) jump_lows++;
      if (game_reset === 1'b0) gr_lows++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", tick); end
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL reset_jump: got %0b want 1", jump); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL reset_pause: got %0b want 1", pause); end
    checks++; if (game_reset !== 1'b1) begin errors++; $display("FAIL reset_game_reset: got %0b want 1", game_reset); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    reset = 1'b1;
    step();
    mdl_run = 1'b0;
    mon_en = 1'b1;
    run_cycles(6);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d want 0", state); end
  endtask

  task automatic test_start();
    start_btn = 1'b0;
    run_cycles(LAT);
    start_btn = 1'b1;
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL start_game_reset: got %0b want 0", game_reset); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL start_pause: got %0b want 0", pause); end
    mdl_run = 1'b1; mdl_div = 0; mdl_score = '0; mdl_level = '0;
    run_cycles(1);
    checks++; if (game_reset !== 1'b1) begin errors++; $display("FAIL game_reset_width: got %0b want 1", game_reset); end
    run_cycles(19);
    checks++; if (score !== 16'd5) begin errors++; $display("FAIL five_ticks_score: got %0d want 5", score); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL five_ticks_level: got %0d want 2", level); end
  endtask

  task automatic test_pause();
    pause_btn = 1'b0;
    run_cycles(LAT);
    pause_btn = 1'b1;
    mdl_run = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d want 2", state); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_out: got %0b want 1", pause); end
    jump_lows = 0;
    jump_btn = 1'b0;
    run_cycles(LAT + 2);
    jump_btn = 1'b1;
    run_cycles(DEB + 4);
    checks++; if (jump_lows !== 0) begin errors++; $display("FAIL paused_jump: jump low cycles=%0d want 0", jump_lows); end
    checks++; if (score !== mdl_score) begin errors++; $display("FAIL paused_score: got %0d want %0d", score, mdl_score); end
    pause_btn = 1'b0;
    run_cycles(LAT);
    pause_btn = 1'b1;
    mdl_run = 1'b1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d want 1", state); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL resume_pause: got %0b want 0", pause); end
    run_cycles(3 * TD + DEB);
  endtask

  task automatic test_jump_hold();
    jump_lows = 0;
    jump_btn = 1'b0;
    run_cycles(50);
    jump_btn = 1'b1;
    run_cycles(DEB + 4);
    checks++; if (jump_lows !== 1) begin errors++; $display("FAIL jump_hold: jump low cycles=%0d want 1", jump_lows); end
  endtask

  task automatic test_start_ignored();
    gr_lows = 0;
    start_btn = 1'b0;
    run_cycles(LAT + 2);
    start_btn = 1'b1;
    run_cycles(DEB + 2);
    checks++; if (gr_lows !== 0) begin errors++; $display("FAIL start_in_run: game_reset low cycles=%0d want 0", gr_lows); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_in_run_state: got %0d want 1", state); end
  endtask

  task automatic test_collision();
    int want;
    want = (((TD - 1 - EV) % TD) + TD) % TD;
    for (int g = 0; g < TD && mdl_div != want; g++) run_cycles(1);
    pause_btn = 1'b0;
    run_cycles(EV);
    collision = 1'b1;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL collision_tick: got %0b want 0", tick); end
    step();
    collision = 1'b0;
    pause_btn = 1'b1;
    mdl_run = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL collision_state: got %0d want 3", state); end
    checks++; if (score !== mdl_score) begin errors++; $display("FAIL collision_score: got %0d want %0d", score, mdl_score); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL over_pause: got %0b want 1", pause); end
    run_cycles(DEB + 6);
    start_btn = 1'b0;
    run_cycles(LAT);
    start_btn = 1'b1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state: got %0d want 1", state); end
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL restart_game_reset: got %0b want 0", game_reset); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL restart_score: got %0d want 0", score); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL restart_level: got %0d want 0", level); end
    mdl_run = 1'b1; mdl_div = 0; mdl_score = '0; mdl_level = '0;
    run_cycles(2 * TD + 1);
  endtask

  task automatic test_reset_mid_round();
    for (int g = 0; g < TD && mdl_div != 1; g++) run_cycles(1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d ticks missing, want 0", exp_q.size()); end
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", state); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL midreset_score: got %0d want 0", score); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL midreset_pause: got %0b want 1", pause); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midreset_tick: got %0b want 0", tick); end
    step();
    reset = 1'b1;
    mdl_run = 1'b0;
    step();
  endtask

`ifdef BTN_DEBOUNCE_EN
  task automatic test_debounce();
    int n;
    start_btn = 1'b0;
    repeat (5) step();
    start_btn = 1'b1;
    repeat (20) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL debounce_glitch: state=%0d want 0", state); end
    start_btn = 1'b0;
    repeat (10) step();
    start_btn = 1'b1;
    n = 0;
    while (state !== 2'd1 && n < 20) begin step(); n++; end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL debounce_press: state=%0d want 1", state); end
  endtask
`endif

  task automatic test_saturation();
    int n;
    s_start = 1'b0;
    repeat (LAT) step();
    s_start = 1'b1;
    checks++; if (s_state !== 2'd1) begin errors++; $display("FAIL sat_start_state: got %0d want 1", s_state); end
    checks++; if (s_game_reset !== 1'b0) begin errors++; $display("FAIL sat_game_reset: got %0b want 0", s_game_reset); end
    checks++; if (s_tick !== 1'b1) begin errors++; $display("FAIL div1_tick: got %0b want 1", s_tick); end
    n = 0;
    while (s_score !== 16'hFFFE && n < 70000) begin step(); n++; end
    checks++; if (n !== 65534) begin errors++; $display("FAIL sat_reach: cycles=%0d want 65534", n); end
    checks++; if (s_level !== 3'd7) begin errors++; $display("FAIL sat_level_pre: got %0d want 7", s_level); end
    step();
    checks++; if (s_score !== 16'hFFFF) begin errors++; $display("FAIL sat_score_max: got %h want ffff", s_score); end
    step();
    step();
    checks++; if (s_score !== 16'hFFFF) begin errors++; $display("FAIL sat_score_hold: got %h want ffff", s_score); end
    checks++; if (s_level !== 3'd7) begin errors++; $display("FAIL sat_level: got %0d want 7", s_level); end
    checks++; if (s_tick !== 1'b1 || s_pause !== 1'b0 || s_jump !== 1'b1) begin
      errors++; $display("FAIL sat_outputs: tick=%0b pause=%0b jump=%0b want 1 0 1", s_tick, s_pause, s_jump);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_jump_hold();
    test_start_ignored();
    test_collision();
    test_reset_mid_round();
`ifdef BTN_DEBOUNCE_EN
    test_debounce();
`endif
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
